// File: rtl/tetris_input_pkg.sv
// Shared definitions for the gamepad front end of the grid controller.
// Holds button bit positions, the one-hot command encoding, the auto-repeat
// state type and the fixed-priority pick used when delivering commands.
package tetris_input_pkg;

    localparam int unsigned BTN_LEFT   = 0;
    localparam int unsigned BTN_RIGHT  = 1;
    localparam int unsigned BTN_DOWN   = 2;
    localparam int unsigned BTN_ROTATE = 3;

    localparam logic [3:0] CMD_NONE   = 4'b0000;
    localparam logic [3:0] CMD_LEFT   = 4'b0001;
    localparam logic [3:0] CMD_RIGHT  = 4'b0010;
    localparam logic [3:0] CMD_DOWN   = 4'b0100;
    localparam logic [3:0] CMD_ROTATE = 4'b1000;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat
    } rpt_state_e;

    // Highest-priority pending event: rotate > down > left > right.
    function automatic logic [3:0] pick_cmd(input logic [3:0] pend);
        if (pend[BTN_ROTATE]) return CMD_ROTATE;
        if (pend[BTN_DOWN])   return CMD_DOWN;
        if (pend[BTN_LEFT])   return CMD_LEFT;
        if (pend[BTN_RIGHT])  return CMD_RIGHT;
        return CMD_NONE;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus tick-based debounce for one raw button line.
// Ports:
//   clock, reset (async, active-high), tick (timebase strobe)
//   raw   - asynchronous button level
//   level - debounced level, changes only after the synchronised input has
//           differed from it for DEBOUNCE_TICKS consecutive ticks
module btn_debounce #(
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          sync;

    assign sync  = sync_q[1];
    assign level = level_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], raw};
            // Any cycle where the input agrees with the accepted level restarts
            // the count, so a bounce gap always clears progress.
            if (sync == level_q) begin
                cnt_q <= '0;
            end else if (tick) begin
                if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
                    level_q <= sync;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/move_request_gen.sv
// Gamepad front end: turns four raw button lines into one-hot move commands
// delivered over a valid/ready handshake to the grid controller.
// Build option: define MOVE_REPEAT_EN to include the auto-repeat FSM for held
// directional buttons; without it every held button yields one command.
// Ports:
//   clock, reset (async, active-high), tick (timebase strobe)
//   buttons_in[3:0] - raw levels: 0 left, 1 right, 2 down, 3 rotate
//   cmd_valid, cmd[3:0], cmd_ready - command handshake (cmd is 0 when idle)
//   pressed[3:0]    - debounced button levels
module move_request_gen
    import tetris_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned REPEAT_DELAY   = 8,
    parameter int unsigned REPEAT_RATE    = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] buttons_in,
    output logic       cmd_valid,
    output logic [3:0] cmd,
    input  logic       cmd_ready,
    output logic [3:0] pressed
);

    logic [3:0] stable;
    logic [3:0] stable_q;
    logic [3:0] press;
    logic [3:0] rep_set;
    logic [3:0] pend_q;
    logic [3:0] pend_d;
    logic [3:0] pick;
    logic [3:0] cmd_q;
    logic       valid_q;
    logic       load;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_deb (
            .clock(clock),
            .reset(reset),
            .tick (tick),
            .raw  (buttons_in[i]),
            .level(stable[i])
        );
    end

    assign press = stable & ~stable_q;

    // The output slot refills whenever it is empty or being accepted this edge.
    assign load = ~valid_q | cmd_ready;

    always_comb begin
        pick = CMD_NONE;
        if (load) begin
            pick = pick_cmd(pend_q);
        end
        // New events are ORed in after the clear so a coincident set wins.
        pend_d = (pend_q & ~pick) | press | rep_set;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable_q <= 4'b0000;
            pend_q   <= 4'b0000;
            cmd_q    <= CMD_NONE;
            valid_q  <= 1'b0;
        end else begin
            stable_q <= stable;
            pend_q   <= pend_d;
            if (load) begin
                cmd_q   <= pick;
                valid_q <= |pend_q;
            end
        end
    end

    assign cmd_valid = valid_q;
    assign cmd       = cmd_q;
    assign pressed   = stable;

`ifdef MOVE_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RCW     = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    rpt_state_e     state_q;
    logic [3:0]     active;
    logic [3:0]     act_q;
    logic [RCW-1:0] rcnt_q;
    logic           rpt_hit;

    // Left and right together cancel each other; rotate never repeats.
    always_comb begin
        active = CMD_NONE;
        if (!(stable[BTN_LEFT] && stable[BTN_RIGHT])) begin
            if (stable[BTN_DOWN]) begin
                active = CMD_DOWN;
            end else if (stable[BTN_LEFT]) begin
                active = CMD_LEFT;
            end else if (stable[BTN_RIGHT]) begin
                active = CMD_RIGHT;
            end
        end
    end

    always_comb begin
        rpt_hit = 1'b0;
        if (tick && (active == act_q)) begin
            unique case (state_q)
                StDelay:  rpt_hit = (rcnt_q == RCW'(REPEAT_DELAY - 1));
                StRepeat: rpt_hit = (rcnt_q == RCW'(REPEAT_RATE - 1));
                default:  rpt_hit = 1'b0;
            endcase
        end
        rep_set = rpt_hit ? act_q : CMD_NONE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            act_q   <= CMD_NONE;
            rcnt_q  <= '0;
        end else if (active != act_q) begin
            act_q   <= active;
            rcnt_q  <= '0;
            state_q <= (active == CMD_NONE) ? StIdle : StDelay;
        end else if (tick) begin
            unique case (state_q)
                StIdle: begin
                    rcnt_q <= '0;
                end
                StDelay, StRepeat: begin
                    if (rpt_hit) begin
                        rcnt_q  <= '0;
                        state_q <= StRepeat;
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    rcnt_q  <= '0;
                end
            endcase
        end
    end
`else
    logic [63:0] unused_rpt_params;
    assign unused_rpt_params = {32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
    assign rep_set = CMD_NONE;
`endif

endmodule

// File: tb/tb_move_request_gen.sv
// Self-checking bench for move_request_gen: directed phase table, reset
// sequence and randomised traffic, all compared against a tick-counting
// reference model.
module tb_move_request_gen;

    localparam int DT = 4;
    localparam int RD = 8;
    localparam int RR = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b1;
    logic [3:0] buttons_in = 4'b0000;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid;
    logic [3:0] cmd;
    logic [3:0] pressed;

    int n_checks = 0;
    int n_pass   = 0;

    move_request_gen #(
        .DEBOUNCE_TICKS(DT),
        .REPEAT_DELAY  (RD),
        .REPEAT_RATE   (RR)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick),
        .buttons_in(buttons_in),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .pressed   (pressed)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    bit [3:0] m_s1, m_s2, m_stab, m_stab_prev, m_pend, m_cmd;
    bit       m_valid;
    int       m_dcnt[4];
    int       m_act;   // -1 none, else button index of the repeating direction
    int       m_held;  // ticks the current direction has been held since it became active

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_stab = 0; m_stab_prev = 0; m_pend = 0; m_cmd = 0;
        m_valid = 0; m_act = -1; m_held = 0;
        for (int i = 0; i < 4; i++) m_dcnt[i] = 0;
    endtask

    task automatic model_step();
        bit [3:0] stab_old = m_stab;
        bit [3:0] pend_old = m_pend;
        bit [3:0] s2_old   = m_s2;
        bit [3:0] press;
        bit [3:0] fire = 4'b0000;
        bit [3:0] clr  = 4'b0000;
        int       order[4] = '{3, 2, 0, 1};
        int       act;
        m_s2 = m_s1;
        m_s1 = buttons_in;
        for (int i = 0; i < 4; i++) begin
            if (s2_old[i] == stab_old[i]) m_dcnt[i] = 0;
            else if (tick) begin
                if (m_dcnt[i] == DT - 1) begin
                    m_stab[i] = s2_old[i];
                    m_dcnt[i] = 0;
                end else m_dcnt[i]++;
            end
        end
        press = stab_old & ~m_stab_prev;
        m_stab_prev = stab_old;
`ifdef MOVE_REPEAT_EN
        act = -1;
        if (!(stab_old[0] && stab_old[1])) begin
            if (stab_old[2]) act = 2;
            else if (stab_old[0]) act = 0;
            else if (stab_old[1]) act = 1;
        end
        if (act != m_act) begin
            m_act  = act;
            m_held = 0;
        end else if (act >= 0 && tick) begin
            m_held++;
            if (m_held >= RD && ((m_held - RD) % RR) == 0) fire[act] = 1'b1;
        end
`else
        act = -1;
        if (act != m_act) m_act = act;
`endif
        if (!m_valid || cmd_ready) begin
            for (int k = 0; k < 4; k++)
                if (clr == 0 && pend_old[order[k]]) clr[order[k]] = 1'b1;
            m_valid = (pend_old != 0);
            m_cmd   = clr;
        end
        m_pend = (pend_old & ~clr) | press | fire;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        else n_pass++;
    endtask

    // One clock: drive at the falling edge, compare outputs, then advance.
    task automatic cycle(input logic [3:0] b, input logic r, input logic t,
                         output bit acc, output logic [3:0] acc_cmd);
        buttons_in = b;
        cmd_ready  = r;
        tick       = t;
        check("outputs_vs_model", 32'({cmd_valid, cmd, pressed}),
              32'({m_valid, m_cmd, m_stab}));
        acc     = cmd_valid && r;
        acc_cmd = cmd;
        @(posedge clock);
        @(negedge clock);
    endtask

    typedef struct {
        logic [3:0] btn;
        logic       rdy;
        int         cycles;
        int         exp_rep;    // accepted commands with auto-repeat built
        int         exp_norep;  // accepted commands without it
        logic [3:0] mask;       // OR of accepted commands when any are expected
    } vec_t;

    vec_t tbl[$];

    initial begin
        bit         acc;
        logic [3:0] acc_cmd;
        int         n;
        int         exp_n;
        logic [3:0] seen;
        logic [3:0] first_cmd;
        logic [3:0] b;

        // Idle
        tbl.push_back('{4'b0000, 1'b1, 12, 0, 0, 4'b0000});
        // Bounce on left: 2-cycle runs never debounce
        for (int i = 0; i < 10; i++)
            tbl.push_back('{(i % 2 == 0) ? 4'b0001 : 4'b0000, 1'b1, 2, 0, 0, 4'b0000});
        tbl.push_back('{4'b0001, 1'b1, 8, 0, 0, 4'b0000});
        tbl.push_back('{4'b0000, 1'b1, 12, 1, 1, 4'b0001});
        // Right held: press plus 8 repeats spread over hold and release
        tbl.push_back('{4'b0010, 1'b1, 30, 6, 1, 4'b0010});
        tbl.push_back('{4'b0000, 1'b1, 12, 3, 0, 4'b0010});
        // Left+right together: one each, no repeats
        tbl.push_back('{4'b0011, 1'b1, 40, 2, 2, 4'b0011});
        tbl.push_back('{4'b0000, 1'b1, 12, 0, 0, 4'b0000});
        // Rotate held: exactly one
        tbl.push_back('{4'b1000, 1'b1, 40, 1, 1, 4'b1000});
        tbl.push_back('{4'b0000, 1'b1, 12, 0, 0, 4'b0000});
        // Backpressure: three presses while stalled, then drain in priority order
        tbl.push_back('{4'b1000, 1'b0, 8, 0, 0, 4'b0000});
        tbl.push_back('{4'b0000, 1'b0, 2, 0, 0, 4'b0000});
        tbl.push_back('{4'b0100, 1'b0, 8, 0, 0, 4'b0000});
        tbl.push_back('{4'b0000, 1'b0, 2, 0, 0, 4'b0000});
        tbl.push_back('{4'b0001, 1'b0, 8, 0, 0, 4'b0000});
        tbl.push_back('{4'b0000, 1'b0, 12, 0, 0, 4'b0000});
        tbl.push_back('{4'b0000, 1'b1, 6, 3, 3, 4'b1101});

        #1 reset = 1'b1;
        #1;
        check("reset_cmd_valid", 32'(cmd_valid), 32'(0));
        check("reset_cmd", 32'(cmd), 32'(0));
        check("reset_pressed", 32'(pressed), 32'(0));
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        foreach (tbl[v]) begin
            n    = 0;
            seen = 4'b0000;
            for (int c = 0; c < tbl[v].cycles; c++) begin
                cycle(tbl[v].btn, tbl[v].rdy, 1'b1, acc, acc_cmd);
                if (acc) begin
                    n++;
                    seen |= acc_cmd;
                end
            end
`ifdef MOVE_REPEAT_EN
            exp_n = tbl[v].exp_rep;
`else
            exp_n = tbl[v].exp_norep;
`endif
            check($sformatf("phase%0d_count", v), 32'(n), 32'(exp_n));
            check($sformatf("phase%0d_cmds", v), 32'(seen),
                  32'((exp_n > 0) ? tbl[v].mask : 4'b0000));
        end

        // Reset in the middle of a repeating hold with a command waiting.
        for (int c = 0; c < 20; c++) cycle(4'b0010, 1'b1, 1'b1, acc, acc_cmd);
        for (int c = 0; c < 3; c++) cycle(4'b0010, 1'b0, 1'b1, acc, acc_cmd);
`ifdef MOVE_REPEAT_EN
        check("stall_before_reset_valid", 32'(cmd_valid), 32'(1));
`else
        check("stall_before_reset_valid", 32'(cmd_valid), 32'(0));
`endif
        #2 reset = 1'b1;
        #1;
        check("midreset_cmd_valid", 32'(cmd_valid), 32'(0));
        check("midreset_cmd", 32'(cmd), 32'(0));
        check("midreset_pressed", 32'(pressed), 32'(0));
        @(negedge clock);
        reset     = 1'b0;
        n         = 0;
        first_cmd = 4'b0000;
        for (int c = 0; c < 30; c++) begin
            cycle(4'b0010, 1'b1, 1'b1, acc, acc_cmd);
            if (acc) begin
                if (n == 0) first_cmd = acc_cmd;
                n++;
            end
        end
`ifdef MOVE_REPEAT_EN
        check("after_reset_count", 32'(n), 32'(6));
`else
        check("after_reset_count", 32'(n), 32'(1));
`endif
        check("after_reset_first_cmd", 32'(first_cmd), 32'(4'b0010));
        for (int c = 0; c < 12; c++) cycle(4'b0000, 1'b1, 1'b1, acc, acc_cmd);

        // Randomised traffic with irregular ticks and backpressure.
        b = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) b = 4'($urandom);
            cycle(b, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7), acc, acc_cmd);
        end
        for (int c = 0; c < 20; c++) cycle(4'b0000, 1'b1, 1'b1, acc, acc_cmd);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
